pwm_duty_decoder: RTL and testbench
===================================

PWM_DUTY_DECODER -- requirements
Module: pwm_duty_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning the width of the period and high-time counters; legal range 5..16.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port pwm_i, input, 1 bit: PWM signal, asynchronous to clk_i.
REQ-005 SHALL have port level_o, output, 4 bits: last decoded duty level, 0..9.
REQ-006 SHALL have port valid_o, output, 1 bit: one-cycle pulse when level_o is updated.
REQ-007 SHALL have port locked_o, output, 1 bit: high while decoding a periodic input.

Function
REQ-008 SHALL pass pwm_i through a 2-flop synchronizer to give pwm_s, plus a delay flop pwm_d; a rise is pwm_s=1 & pwm_d=0.
REQ-009 SHALL keep period_cnt: load 1 on a rise cycle, otherwise increment, saturating at MAX=2^CNT_W-1.
REQ-010 SHALL keep high_cnt: load 1 on a rise cycle, otherwise increment when pwm_s=1, saturating at MAX.
REQ-011 SHALL use FSM states IDLE, MEASURE and CALC.
REQ-012 IDLE SHALL, on a rise, go to MEASURE without producing a result (first edge only starts a measurement).
REQ-013 MEASURE SHALL, on a rise in cycle R, latch P=period_cnt and H=high_cnt (pre-reload values), then go to CALC with k=1.
REQ-014 CALC SHALL take one iteration per cycle for k=1..9 (cycles R+1..R+9): if 10*H >= k*P then lvl_tmp=k; lvl_tmp SHALL start at 0.
REQ-015 Arithmetic SHALL be unsigned at CNT_W+4 bits; the result is floor(10*H/P) clamped to 9.
REQ-016 At the edge ending iteration k=9, the block SHALL set level_o=lvl_tmp, valid_o=1 (cycle R+10 only), locked_o=1, and the FSM SHALL go to MEASURE.
REQ-017 A rise during CALC (cycles R+1..R+9) SHALL reload the counters normally, but its completed period SHALL be discarded; a rise in cycle R+10 SHALL be accepted.
REQ-018 Timeout SHALL fire when period_cnt==MAX and timed_out=0, in any state.
REQ-019 On timeout, the next cycle SHALL show level_o=9 if pwm_s=1 else 0, valid_o=1 for one cycle, and locked_o=0; the block SHALL set timed_out=1 and the FSM SHALL go to IDLE.
REQ-020 timed_out SHALL clear on any rise; no further timeout pulses SHALL occur while it is set.
REQ-021 valid_o SHALL never be high in two consecutive cycles.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 While rst_i=1 at a clock edge, the block SHALL clear the synchronizer flops, pwm_d, period_cnt, high_cnt, P, H, k, lvl_tmp and timed_out, and set the FSM to IDLE.
REQ-024 While rst_i=1 at a clock edge, the block SHALL drive level_o=0, valid_o=0 and locked_o=0.
REQ-025 Reset asserted during CALC SHALL abort it; no valid_o pulse SHALL result.
REQ-026 No rise SHALL be detected in the first cycle after reset release unless pwm_s is 1.

Verification
REQ-027 Reset, pwm_i=0 held: level_o=0, valid_o=0, locked_o=0; first valid_o exactly 256 cycles after reset release (CNT_W=8), level_o=0, locked_o=0.
REQ-028 Period 20, high 7 (synchronous stimulus): no valid_o on the first rise; then valid_o 10 cycles after each internal rise, level_o=3, locked_o=1.
REQ-029 Period 40: high 39 -> level_o=9; high 3 -> level_o=0; high 4 -> level_o=1 (boundary 10*H==P).
REQ-030 Period 8, high 4: every second rise is discarded; valid_o every 16 cycles, level_o=5.
REQ-031 pwm_i stuck high after lock at level 3: exactly one valid_o with level_o=9 and locked_o=0, then silence; resume a period-20 input -> relock after two rises.
REQ-032 rst_i pulsed at cycle R+5 of a CALC: no valid_o; all outputs 0 the next cycle; the next result requires two new rises.

Source files
------------

// File: rtl/pwm_duty_decoder.sv
// Measures the duty cycle of an asynchronous PWM input and reports it as a
// level 0..9 (floor of 10*high/period, clamped), with lock and timeout tracking.
module pwm_duty_decoder #(
    parameter int CNT_W = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pwm_i,
    output logic [3:0] level_o,
    output logic       valid_o,
    output logic       locked_o
);

    localparam int               CALC_W  = CNT_W + 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_CALC
    } state_t;

    logic              sync1_q;
    logic              pwm_s_q;
    logic              pwm_d_q;
    logic              rise;

    logic [CNT_W-1:0]  period_cnt_q;
    logic [CNT_W-1:0]  period_cnt_d;
    logic [CNT_W-1:0]  high_cnt_q;
    logic [CNT_W-1:0]  high_cnt_d;

    state_t            state_q;
    logic [CNT_W-1:0]  p_q;
    logic [CNT_W-1:0]  h_q;
    logic [3:0]        k_q;
    logic [3:0]        lvl_tmp_q;
    logic [3:0]        lvl_next;
    logic              timed_out_q;
    logic              timeout;

    logic [3:0]        level_q;
    logic              valid_q;
    logic              locked_q;

    logic [CALC_W-1:0] ten_h;
    logic [CALC_W-1:0] k_p;

    assign rise    = pwm_s_q & ~pwm_d_q;
    assign timeout = (period_cnt_q == CNT_MAX) && !timed_out_q;

    // One threshold test per CALC cycle: level k is reached when 10*H >= k*P.
    assign ten_h    = (CALC_W'(h_q) << 3) + (CALC_W'(h_q) << 1);
    assign k_p      = CALC_W'(k_q) * CALC_W'(p_q);
    assign lvl_next = (ten_h >= k_p) ? k_q : lvl_tmp_q;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        if (rise) begin
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
        end else begin
            if (period_cnt_q != CNT_MAX) begin
                period_cnt_d = period_cnt_q + CNT_ONE;
            end
            if (pwm_s_q && (high_cnt_q != CNT_MAX)) begin
                high_cnt_d = high_cnt_q + CNT_ONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours (the synchronizer chain depends on it).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q      <= 1'b0;
            pwm_s_q      <= 1'b0;
            pwm_d_q      <= 1'b0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
        end else begin
            sync1_q      <= pwm_i;
            pwm_s_q      <= sync1_q;
            pwm_d_q      <= pwm_s_q;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
        end
    end

    // Timeout outranks the measurement FSM: a stalled input aborts any CALC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            p_q         <= '0;
            h_q         <= '0;
            k_q         <= 4'd0;
            lvl_tmp_q   <= 4'd0;
            timed_out_q <= 1'b0;
            level_q     <= 4'd0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (rise) begin
                timed_out_q <= 1'b0;
            end

            if (timeout) begin
                timed_out_q <= 1'b1;
                level_q     <= pwm_s_q ? 4'd9 : 4'd0;
                valid_q     <= 1'b1;
                locked_q    <= 1'b0;
                state_q     <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (rise) begin
                            state_q <= S_MEASURE;
                        end
                    end
                    S_MEASURE: begin
                        if (rise) begin
                            p_q       <= period_cnt_q;
                            h_q       <= high_cnt_q;
                            k_q       <= 4'd1;
                            lvl_tmp_q <= 4'd0;
                            state_q   <= S_CALC;
                        end
                    end
                    S_CALC: begin
                        // Rises seen here reload the counters but do not restart CALC.
                        lvl_tmp_q <= lvl_next;
                        k_q       <= k_q + 4'd1;
                        if (k_q == 4'd9) begin
                            level_q  <= lvl_next;
                            valid_q  <= 1'b1;
                            locked_q <= 1'b1;
                            state_q  <= S_MEASURE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign level_o  = level_q;
    assign valid_o  = valid_q;
    assign locked_o = locked_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: one input step per clock, valid pulses
// logged with their step index and compared against hand-derived schedules.
module tb_pwm_duty_decoder;

    localparam int CNT_W = 8;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       pwm_i = 1'b0;
    logic [3:0] level_o;
    logic       valid_o;
    logic       locked_o;

    pwm_duty_decoder #(.CNT_W(CNT_W)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .pwm_i    (pwm_i),
        .level_o  (level_o),
        .valid_o  (valid_o),
        .locked_o (locked_o)
    );

    always #5 clk_i = ~clk_i;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         v_cyc[$];
    logic [3:0] v_lvl[$];
    logic       v_lock[$];
    logic       prev_valid = 1'b0;

    // Drive one step (inputs change at the negedge), then sample at the next negedge.
    task automatic step(input logic p, input logic r);
        pwm_i = p;
        rst_i = r;
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
        if (valid_o === 1'b1) begin
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL valid_adjacent: valid_o high at steps %0d and %0d, required non-consecutive", cyc - 1, cyc);
            end
            v_cyc.push_back(cyc);
            v_lvl.push_back(level_o);
            v_lock.push_back(locked_o);
        end
        prev_valid = (valid_o === 1'b1);
    endtask

    task automatic clear_log();
        v_cyc.delete();
        v_lvl.delete();
        v_lock.delete();
    endtask

    task automatic idle(input int n, input logic p);
        for (int i = 0; i < n; i++) step(p, 1'b0);
    endtask

    task automatic run_pwm(input int period, input int high, input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < period; j++) step(j < high, 1'b0);
        end
    endtask

    task automatic apply_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if ({level_o, valid_o, locked_o} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs: level=%0d valid=%b locked=%b, required 0/0/0", level_o, valid_o, locked_o);
            end
        end
        clear_log();
    endtask

    task automatic test_reset();
        apply_reset();
        step(1'b1, 1'b0);
        checks++;
        if ({level_o, valid_o, locked_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_release: level=%0d valid=%b locked=%b, required 0/0/0", level_o, valid_o, locked_o);
        end
    endtask

    task automatic test_timeout_idle();
        int r0;
        apply_reset();
        r0 = cyc;
        idle(300, 1'b0);
        checks++;
        if (v_cyc.size() != 1) begin
            errors++;
            $display("FAIL idle_timeout_count: got %0d valid pulses, required 1", v_cyc.size());
        end
        if (v_cyc.size() >= 1) begin
            checks += 3;
            if (v_cyc[0] != r0 + 256) begin
                errors++;
                $display("FAIL idle_timeout_time: valid %0d cycles after release, required 256", v_cyc[0] - r0);
            end
            if (v_lvl[0] !== 4'd0) begin
                errors++;
                $display("FAIL idle_timeout_level: got %0d, required 0", v_lvl[0]);
            end
            if (v_lock[0] !== 1'b0) begin
                errors++;
                $display("FAIL idle_timeout_locked: got %b, required 0", v_lock[0]);
            end
        end
    endtask

    task automatic test_period20();
        int s0;
        apply_reset();
        idle(3, 1'b0);
        s0 = cyc + 1;
        run_pwm(20, 7, 5);
        idle(12, 1'b0);
        checks++;
        if (v_cyc.size() != 4) begin
            errors++;
            $display("FAIL p20_count: got %0d valid pulses, required 4", v_cyc.size());
        end
        for (int i = 0; i < v_cyc.size() && i < 4; i++) begin
            checks++;
            if (v_cyc[i] != s0 + 31 + 20 * i || v_lvl[i] !== 4'd3 || v_lock[i] !== 1'b1) begin
                errors++;
                $display("FAIL p20_result[%0d]: step=%0d level=%0d locked=%b, required step=%0d level=3 locked=1",
                         i, v_cyc[i] - s0, v_lvl[i], v_lock[i], 31 + 20 * i);
            end
        end
    endtask

    task automatic test_levels();
        int hi_tab[3] = '{39, 3, 4};
        int lv_tab[3] = '{9, 0, 1};
        int s0;
        for (int t = 0; t < 3; t++) begin
            apply_reset();
            idle(3, 1'b0);
            s0 = cyc + 1;
            run_pwm(40, hi_tab[t], 3);
            idle(12, 1'b0);
            checks++;
            if (v_cyc.size() != 2) begin
                errors++;
                $display("FAIL level_h%0d_count: got %0d valid pulses, required 2", hi_tab[t], v_cyc.size());
            end
            for (int i = 0; i < v_cyc.size() && i < 2; i++) begin
                checks++;
                if (v_cyc[i] != s0 + 51 + 40 * i || v_lvl[i] !== 4'(lv_tab[t]) || v_lock[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL level_h%0d[%0d]: step=%0d level=%0d locked=%b, required step=%0d level=%0d locked=1",
                             hi_tab[t], i, v_cyc[i] - s0, v_lvl[i], v_lock[i], 51 + 40 * i, lv_tab[t]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        apply_reset();
        idle(3, 1'b0);
        s0 = cyc + 1;
        run_pwm(8, 4, 8);
        idle(12, 1'b0);
        checks++;
        if (v_cyc.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d valid pulses, required 4", v_cyc.size());
        end
        for (int i = 0; i < v_cyc.size() && i < 4; i++) begin
            checks++;
            if (v_cyc[i] != s0 + 19 + 16 * i || v_lvl[i] !== 4'd5 || v_lock[i] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_result[%0d]: step=%0d level=%0d locked=%b, required step=%0d level=5 locked=1",
                         i, v_cyc[i] - s0, v_lvl[i], v_lock[i], 19 + 16 * i);
            end
        end
    endtask

    task automatic test_stuck_high();
        int s0, s1, t0;
        int         e_cyc[6];
        logic [3:0] e_lvl[6] = '{4'd3, 4'd3, 4'd3, 4'd9, 4'd3, 4'd3};
        logic       e_lck[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        apply_reset();
        idle(3, 1'b0);
        s0 = cyc + 1;
        run_pwm(20, 7, 3);
        s1 = cyc + 1;
        idle(400, 1'b1);
        idle(13, 1'b0);
        t0 = cyc + 1;
        run_pwm(20, 7, 3);
        idle(12, 1'b0);
        e_cyc = '{s0 + 31, s0 + 51, s0 + 71, s1 + 257, t0 + 31, t0 + 51};
        checks++;
        if (v_cyc.size() != 6) begin
            errors++;
            $display("FAIL stuck_count: got %0d valid pulses, required 6", v_cyc.size());
        end
        for (int i = 0; i < v_cyc.size() && i < 6; i++) begin
            checks++;
            if (v_cyc[i] != e_cyc[i] || v_lvl[i] !== e_lvl[i] || v_lock[i] !== e_lck[i]) begin
                errors++;
                $display("FAIL stuck_result[%0d]: step=%0d level=%0d locked=%b, required step=%0d level=%0d locked=%b",
                         i, v_cyc[i] - s0, v_lvl[i], v_lock[i], e_cyc[i] - s0, e_lvl[i], e_lck[i]);
            end
        end
    endtask

    task automatic test_reset_in_calc();
        int s0;
        int e_off[4] = '{31, 51, 111, 131};
        apply_reset();
        idle(3, 1'b0);
        s0 = cyc + 1;
        run_pwm(20, 7, 3);
        for (int j = 0; j < 20; j++) begin
            step(j < 7, j == 7);
            if (j == 7) begin
                checks++;
                if ({level_o, valid_o, locked_o} !== 6'b0) begin
                    errors++;
                    $display("FAIL calc_abort_outputs: level=%0d valid=%b locked=%b, required 0/0/0", level_o, valid_o, locked_o);
                end
            end
        end
        run_pwm(20, 7, 3);
        idle(12, 1'b0);
        checks++;
        if (v_cyc.size() != 4) begin
            errors++;
            $display("FAIL calc_abort_count: got %0d valid pulses, required 4", v_cyc.size());
        end
        for (int i = 0; i < v_cyc.size() && i < 4; i++) begin
            checks++;
            if (v_cyc[i] != s0 + e_off[i] || v_lvl[i] !== 4'd3 || v_lock[i] !== 1'b1) begin
                errors++;
                $display("FAIL calc_abort_result[%0d]: step=%0d level=%0d locked=%b, required step=%0d level=3 locked=1",
                         i, v_cyc[i] - s0, v_lvl[i], v_lock[i], e_off[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_timeout_idle();
        test_period20();
        test_levels();
        test_back_to_back();
        test_stuck_high();
        test_reset_in_calc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
